// File: rtl/timer_dev.sv
// timer_dev: bus-programmable down-counter timer with a masked interrupt; optional auto-reload via TIMER_AUTORELOAD_EN.
// Latency: IRQ rises N+3 edges after the Enable write (PRESET=N); DOUT is combinational; no backpressure, writes always accepted.
module timer_dev #(
    parameter logic [31:0] PRESET_RST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:2]  Addr,
    input  logic        WE,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        IRQ
);

    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_reload;
    logic [3:0]  w_ctrl_wdat;

    assign w_wr_ctrl   = WE && (Addr == 2'd0);
    assign w_wr_preset = WE && (Addr == 2'd1);

`ifdef TIMER_AUTORELOAD_EN
    assign w_ctrl_wdat = DIN[3:0];
    assign w_reload    = (r_ctrl[2:1] == 2'b01);
`else
    assign w_ctrl_wdat = {DIN[3], 2'b00, DIN[0]};
    assign w_reload    = 1'b0;
`endif

    // Later assignments override earlier ones: an INT-entry flag set beats a same-edge write clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ctrl     <= 4'h0;
            r_preset   <= PRESET_RST;
            r_count    <= 32'h0;
            r_irq_flag <= 1'b0;
        end else begin
            if (w_wr_ctrl)
                r_ctrl <= w_ctrl_wdat;
            if (w_wr_preset)
                r_preset <= DIN;
            if (w_wr_ctrl || w_wr_preset)
                r_irq_flag <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_ctrl[0])
                        r_state <= LOAD;
                end
                LOAD: begin
                    r_count <= r_preset;
                    r_state <= CNT;
                end
                CNT: begin
                    if (!r_ctrl[0]) begin
                        r_state <= IDLE;
                    end else if (r_count != 32'h0) begin
                        r_count <= r_count - 32'd1;
                    end else begin
                        r_state    <= INT;
                        r_irq_flag <= 1'b1;
                    end
                end
                INT: begin
                    r_state <= IDLE;
                    // A CTRL write landing on this edge keeps its own Enable value.
                    if (w_reload)
                        r_irq_flag <= 1'b0;
                    else if (!w_wr_ctrl)
                        r_ctrl[0] <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign IRQ = r_irq_flag & r_ctrl[3];

    always_comb begin
        DOUT = 32'h0;
        case (Addr)
            2'd0:    DOUT = {28'b0, r_ctrl};
            2'd1:    DOUT = r_preset;
            2'd2:    DOUT = r_count;
            default: DOUT = 32'h0;
        endcase
    end

endmodule
